multicycle_control: RTL and testbench

Moore-style control FSM for the multicycle MIPS core, sitting directly upstream of `Data_Path`. It consumes the `OP` and `Funct` fields latched in the datapath instruction register, plus the ALU zero flag. Each cycle it drives every datapath control strobe, sequencing fetch, decode, execute, memory and write-back for R-type, `lw`, `sw`, `beq` and `addi`.

---
 rtl/control_pkg.sv | 25 ++
 rtl/alu_decoder.sv | 14 +
 rtl/multicycle_control.sv | 79 +++++++
 tb/tb_multicycle_control.sv | 117 +++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: shared state encoding, opcode/funct constants, ALU and ALUSrcB codes for the multicycle control FSM
package control_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: R-type funct_i -> alu_ctl_o operation code and funct_valid_o legality flag
module alu_decoder
  import control_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctl_o,
  output logic       funct_valid_o
);
  assign alu_ctl_o = funct_i == FN_SUB ? ALU_SUB :
                     funct_i == FN_AND ? ALU_AND :
                     funct_i == FN_OR  ? ALU_OR  :
                     funct_i == FN_SLT ? ALU_SLT : ALU_ADD;
  assign funct_valid_o = funct_i inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: MIPS multicycle Moore control FSM; in clk/reset(n)/OP/Funct/Zero, out datapath strobes, instr_done_o, sticky illegal_o
module multicycle_control
  import control_pkg::*;
#(
  parameter int ALU_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       OP,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [ALU_W-1:0] ALUControl,
  output logic             PCSrc,
  output logic             instr_done_o,
  output logic             illegal_o
);
  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] fn_ctl;
  logic       fn_ok;
  alu_decoder u_dec (
    .funct_i      (Funct),
    .alu_ctl_o    (fn_ctl),
    .funct_valid_o(fn_ok)
  );
  always_comb begin
    state_d   = FETCH;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        state_d = (OP == OP_LW || OP == OP_SW)  ? MEMADR   :
                  (OP == OP_RTYPE && fn_ok)     ? EXECUTE  :
                  OP == OP_BEQ                  ? BRANCH   :
                  OP == OP_ADDI                 ? ADDIEXEC : FETCH;
        illegal_d = illegal_q | (state_d == FETCH);
      end
      MEMADR:   state_d = OP == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end
  assign PCWrite      = reset & (state_q == FETCH | (state_q == BRANCH & Zero));
  assign IorD         = state_q == MEMREAD | state_q == MEMWRITE;
  assign MemWrite     = reset & state_q == MEMWRITE;
  assign IRWrite      = reset & state_q == FETCH;
  assign RegDst       = state_q == ALUWB;
  assign MemtoReg     = state_q == MEMWB;
  assign RegWrite     = reset & (state_q == MEMWB | state_q == ALUWB | state_q == ADDIWB);
  assign ALUSrcA      = state_q == MEMADR | state_q == EXECUTE | state_q == BRANCH | state_q == ADDIEXEC;
  assign ALUSrcB      = state_q == FETCH  ? SRCB_4    :
                        state_q == DECODE ? SRCB_IMM2 :
                        (state_q == MEMADR | state_q == ADDIEXEC) ? SRCB_IMM : SRCB_B;
  assign ALUControl   = ALU_W'(state_q == EXECUTE ? fn_ctl : state_q == BRANCH ? ALU_SUB : ALU_ADD);
  assign PCSrc        = state_q == BRANCH;
  assign instr_done_o = state_q == MEMWB | state_q == MEMWRITE | state_q == ALUWB |
                        state_q == BRANCH | state_q == ADDIWB;
  assign illegal_o    = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random and directed instruction streams checked cycle-by-cycle against a per-instruction control table model
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP, Funct;
  logic       Zero;
  logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc, instr_done_o, illegal_o;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;
  logic [16:0] outs;
  int n_cmp = 0, n_bad = 0;
  logic il;
  logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  logic [3:0] alus[5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};
  logic [5:0] ops [5] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08};
  multicycle_control #(.ALU_W(4)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o)
  );
  always #5 clk = ~clk;
  assign outs = {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUControl, PCSrc, instr_done_o, illegal_o};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [16:0] mk(input logic [7:0] s, input logic [1:0] sb, input logic [3:0] ac,
                                     input logic ps, input logic dn);
    return {s, sb, ac, ps, dn, il};
  endfunction
  function automatic int fn_idx(input logic [5:0] f);
    for (int i = 0; i < 5; i++) if (fns[i] == f) return i;
    return -1;
  endfunction
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int ncyc);
    logic [16:0] q[$];
    logic bad;
    int k;
    OP = op;
    Funct = fn;
    Zero = z;
    bad = 1'b0;
    k = fn_idx(fn);
    q.push_back(mk(8'b10010000, 2'b01, 4'b0010, 1'b0, 1'b0));
    q.push_back(mk(8'b00000000, 2'b11, 4'b0010, 1'b0, 1'b0));
    if (op == 6'h23) begin
      q.push_back(mk(8'b00000001, 2'b10, 4'b0010, 1'b0, 1'b0));
      q.push_back(mk(8'b01000000, 2'b00, 4'b0010, 1'b0, 1'b0));
      q.push_back(mk(8'b00000110, 2'b00, 4'b0010, 1'b0, 1'b1));
    end else if (op == 6'h2b) begin
      q.push_back(mk(8'b00000001, 2'b10, 4'b0010, 1'b0, 1'b0));
      q.push_back(mk(8'b01100000, 2'b00, 4'b0010, 1'b0, 1'b1));
    end else if (op == 6'h00 && k >= 0) begin
      q.push_back(mk(8'b00000001, 2'b00, alus[k], 1'b0, 1'b0));
      q.push_back(mk(8'b00001010, 2'b00, 4'b0010, 1'b0, 1'b1));
    end else if (op == 6'h04) begin
      q.push_back(mk({z, 7'b0000001}, 2'b00, 4'b0110, 1'b1, 1'b1));
    end else if (op == 6'h08) begin
      q.push_back(mk(8'b00000001, 2'b10, 4'b0010, 1'b0, 1'b0));
      q.push_back(mk(8'b00000010, 2'b00, 4'b0010, 1'b0, 1'b1));
    end else bad = 1'b1;
    if (ncyc > q.size()) ncyc = q.size();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check($sformatf("op%02h_fn%02h_z%0d_c%0d", op, fn, z, i + 1), 32'(outs), 32'(q[i]));
      @(posedge clk);
      #1;
    end
    if (bad && ncyc == q.size()) il = 1'b1;
  endtask
  initial begin
    logic [5:0] op, fn;
    reset = 1'b0;
    OP = 6'h00;
    Funct = 6'h20;
    Zero = 1'b0;
    il = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_rst_we", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(6'h3f, 6'h20, 1'b0, 9);
    run_instr(6'h00, 6'h01, 1'b0, 9);
    run_instr(6'h23, 6'h00, 1'b0, 9);
    run_instr(6'h2b, 6'h00, 1'b1, 9);
    for (int i = 0; i < 5; i++) run_instr(6'h00, fns[i], 1'b0, 9);
    run_instr(6'h04, 6'h00, 1'b1, 9);
    run_instr(6'h04, 6'h00, 1'b0, 9);
    run_instr(6'h08, 6'h00, 1'b0, 9);
    run_instr(6'h23, 6'h00, 1'b0, 3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_we_c%0d", i), 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    il = 1'b0;
    run_instr(6'h23, 6'h00, 1'b0, 9);
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 5) == 5 ? 6'($urandom) : ops[$urandom_range(0, 4)];
      fn = $urandom_range(0, 3) == 0 ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(op, fn, 1'($urandom), 9);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
